// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS pipelined instruction-fetch stage with handshaked imem port and IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcplus4
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] fetch_addr, fetch_addr_nx;
    logic [31:0] pend_pc, pend_pc_nx;
    logic [31:0] hold_word, hold_word_nx;
    logic        id_valid_nx;
    logic [31:0] id_instr_nx, id_pc_nx, id_pcplus4_nx;
    logic        id_accept;
    logic [31:0] addr_inc;

    assign id_accept = !stall || !id_valid;
    assign addr_inc  = fetch_addr + 32'd4;
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = fetch_addr;

    always_comb begin
        state_nx      = state;
        fetch_addr_nx = fetch_addr;
        pend_pc_nx    = pend_pc;
        hold_word_nx  = hold_word;
        id_valid_nx   = id_valid;
        id_instr_nx   = id_instr;
        id_pc_nx      = id_pc;
        id_pcplus4_nx = id_pcplus4;
        case (state)
            BOOT: state_nx = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    id_valid_nx = 1'b0;
                    id_instr_nx = NOP;
                    if (imem_ready) begin
                        fetch_addr_nx = redirect_pc;
                    end else begin
                        // Access already in flight: remember the target and wait it out.
                        pend_pc_nx = redirect_pc;
                        state_nx   = DRAIN;
                    end
                end else if (imem_ready && id_accept) begin
                    id_valid_nx   = 1'b1;
                    id_instr_nx   = imem_rdata;
                    id_pc_nx      = fetch_addr;
                    id_pcplus4_nx = addr_inc;
                    fetch_addr_nx = addr_inc;
                end else if (imem_ready) begin
                    hold_word_nx = imem_rdata;
                    state_nx     = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    id_valid_nx   = 1'b0;
                    id_instr_nx   = NOP;
                    fetch_addr_nx = redirect_pc;
                    state_nx      = FETCH;
                end else if (!stall) begin
                    id_valid_nx   = 1'b1;
                    id_instr_nx   = hold_word;
                    id_pc_nx      = fetch_addr;
                    id_pcplus4_nx = addr_inc;
                    fetch_addr_nx = addr_inc;
                    state_nx      = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pend_pc_nx = redirect_pc;
                end
                if (imem_ready) begin
                    fetch_addr_nx = redirect_valid ? redirect_pc : pend_pc;
                    state_nx      = FETCH;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            fetch_addr <= RESET_PC;
            pend_pc    <= 32'd0;
            hold_word  <= 32'd0;
            id_valid   <= 1'b0;
            id_instr   <= NOP;
            id_pc      <= 32'd0;
            id_pcplus4 <= 32'd0;
        end else begin
            state      <= state_nx;
            fetch_addr <= fetch_addr_nx;
            pend_pc    <= pend_pc_nx;
            hold_word  <= hold_word_nx;
            id_valid   <= id_valid_nx;
            id_instr   <= id_instr_nx;
            id_pc      <= id_pc_nx;
            id_pcplus4 <= id_pcplus4_nx;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and randomized bench for if_stage against a transaction-level model
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;

    int n_chk  = 0;
    int n_fail = 0;

    if_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pcplus4(id_pcplus4)
    );

    always #5 clk = ~clk;

    // Reference: booted/held/discarding flags plus the next address to fetch.
    bit          m_booted, m_held, m_discard;
    logic [31:0] m_fa, m_pend, m_buf;
    logic        m_idv;
    logic [31:0] m_idi, m_idpc, m_idp4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_booted = 0; m_held = 0; m_discard = 0;
        m_fa = RESET_PC; m_pend = 0; m_buf = 0;
        m_idv = 0; m_idi = NOP; m_idpc = 0; m_idp4 = 0;
    endtask

    task automatic deliver(input logic [31:0] w, input logic [31:0] a);
        m_idv = 1; m_idi = w; m_idpc = a; m_idp4 = a + 32'd4; m_fa = a + 32'd4;
    endtask

    task automatic flush();
        m_idv = 0; m_idi = NOP;
    endtask

    task automatic model_edge(input logic s, input logic rv, input logic [31:0] rp, input logic rdy);
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_held) begin
            if (rv) begin
                flush(); m_held = 0; m_fa = rp;
            end else if (!s) begin
                deliver(m_buf, m_fa); m_held = 0;
            end
        end else if (m_discard) begin
            if (rv) m_pend = rp;
            if (rdy) begin
                m_fa = rv ? rp : m_pend; m_discard = 0;
            end
        end else begin
            if (rv) begin
                flush();
                if (rdy) m_fa = rp;
                else begin m_pend = rp; m_discard = 1; end
            end else if (rdy && (!s || !m_idv)) begin
                deliver(mem_word(m_fa), m_fa);
            end else if (rdy) begin
                m_buf = mem_word(m_fa); m_held = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_req",   {31'd0, imem_req}, {31'd0, (m_booted && !m_held)});
        chk("imem_addr",  imem_addr, m_fa);
        chk("id_valid",   {31'd0, id_valid}, {31'd0, m_idv});
        chk("id_instr",   id_instr, m_idi);
        chk("id_pc",      id_pc, m_idpc);
        chk("id_pcplus4", id_pcplus4, m_idp4);
    endtask

    task automatic step(input logic s, input logic rv, input logic [31:0] rp, input logic rdy);
        stall = s; redirect_valid = rv; redirect_pc = rp; imem_ready = rdy;
        imem_rdata = rdy ? mem_word(imem_addr) : $urandom;
        model_edge(s, rv, rp, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        imem_ready = 0; imem_rdata = 0;
        model_reset();
        #12;
        check_all();
        rst_n = 1;
        check_all();

        // sequential fetch, zero-wait
        repeat (5) step(0, 0, 0, 1);
        chk("seq_pc", id_pc, 32'h0C);
        chk("seq_addr", imem_addr, 32'h10);

        // stall while 0x10 completes
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("hold_pc", id_pc, 32'h0C);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        step(0, 0, 0, 0);
        chk("release_pc", id_pc, 32'h10);
        chk("release_addr", imem_addr, 32'h14);

        // ready every third cycle
        for (int i = 0; i < 9; i++) step(0, 0, 0, (i % 3) == 2);
        chk("wait_addr", imem_addr, 32'h20);

        // redirect during a waiting fetch
        step(0, 0, 0, 0);
        step(0, 1, 32'h100, 0);
        step(0, 0, 0, 0);
        chk("drain_addr", imem_addr, 32'h20);
        chk("drain_valid", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 1);
        chk("redir_addr", imem_addr, 32'h100);
        step(0, 0, 0, 1);
        chk("redir_pc", id_pc, 32'h100);

        // double redirect while draining
        step(0, 1, 32'h100, 0);
        step(0, 1, 32'h200, 0);
        step(0, 0, 0, 1);
        chk("dbl_addr", imem_addr, 32'h200);

        // redirect + stall in HOLD, then wrap
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 32'hFFFF_FFFC, 0);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_instr", id_instr, NOP);
        chk("flush_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("wrap_p4", id_pcplus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 r & 32'hFFFF_FFFC, $urandom_range(0, 2) != 0);
        end

        // reset mid-access
        step(0, 0, 0, 0);
        #3;
        rst_n = 0;
        model_reset();
        #1;
        check_all();
        #2;
        rst_n = 1;
        repeat (4) step(0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
